// File: rtl/riscv_mc_pkg.sv
// Shared types and constants for the multi-cycle RV32I controller: state
// encoding, opcodes, ALU operation codes and datapath mux selects.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECR    = 4'd6,
    ST_EXECI    = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JAL      = 4'd10,
    ST_HALT     = 4'd11
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Carry follows the "no borrow" convention, so unsigned-less-than is !carry.
  function automatic logic branchTaken(input logic [2:0] funct3,
                                       input logic zero, input logic neg,
                                       input logic ovf, input logic carry);
    logic taken;
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = neg ^ ovf;
      3'b101:  taken = !(neg ^ ovf);
      3'b110:  taken = !carry;
      3'b111:  taken = carry;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/riscv_mc_alu_decoder.sv
// Combinational decode of ALU operation, immediate format and funct legality
// from the instruction fields and the current controller state.
module riscv_mc_alu_decoder
  import riscv_mc_pkg::*;
#(
  parameter int EXT_BRANCHES = 1
) (
  input  state_e     state_i,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o,
  output logic [1:0] imm_src_o,
  output logic       funct_illegal_o
);

  logic [2:0] aluFunct;
  logic       aluFunctIllegal;
  logic       branchIllegal;

  // Shifts have no ALU code in this core, so funct3 001/101 are rejected.
  always_comb begin
    aluFunct        = ALU_ADD;
    aluFunctIllegal = 1'b0;
    case (funct3_i)
      3'b000:  aluFunct = (state_i == ST_EXECR && funct7b5_i) ? ALU_SUB : ALU_ADD;
      3'b010:  aluFunct = ALU_SLT;
      3'b011:  aluFunct = ALU_SLTU;
      3'b100:  aluFunct = ALU_XOR;
      3'b110:  aluFunct = ALU_OR;
      3'b111:  aluFunct = ALU_AND;
      default: aluFunctIllegal = 1'b1;
    endcase
  end

  always_comb begin
    branchIllegal = 1'b1;
    case (funct3_i)
      3'b000:                               branchIllegal = 1'b0;
      3'b001, 3'b100, 3'b101, 3'b110, 3'b111: branchIllegal = (EXT_BRANCHES == 0);
      default:                              branchIllegal = 1'b1;
    endcase
  end

  always_comb begin
    imm_src_o       = IMM_I;
    funct_illegal_o = 1'b0;
    case (op_i)
      OP_STORE:           imm_src_o = IMM_S;
      OP_BRANCH: begin
        imm_src_o       = IMM_B;
        funct_illegal_o = branchIllegal;
      end
      OP_JAL:             imm_src_o = IMM_J;
      OP_RTYPE, OP_ITYPE: funct_illegal_o = aluFunctIllegal;
      default:            imm_src_o = IMM_I;
    endcase
  end

  always_comb begin
    alu_control_o = ALU_ADD;
    case (state_i)
      ST_BRANCH:          alu_control_o = ALU_SUB;
      ST_EXECR, ST_EXECI: alu_control_o = aluFunct;
      default:            alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_mc_control.sv
// Multi-cycle Moore controller for the RV32I core: sequences fetch, decode,
// execute, memory and writeback over one shared memory port.
module riscv_mc_control
  import riscv_mc_pkg::*;
#(
  parameter int MEM_HANDSHAKE   = 1,
  parameter int EXT_BRANCHES    = 1,
  parameter int TRAP_ON_ILLEGAL = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       alu_zero,
  input  logic       alu_neg,
  input  logic       alu_ovf,
  input  logic       alu_carry,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  localparam state_e ILLEGAL_NEXT = (TRAP_ON_ILLEGAL != 0) ? ST_HALT : ST_FETCH;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;

  logic done;
  logic taken;
  logic functIllegal;
  logic memReqS, memWeS, irWriteS, pcWriteS, regWriteS;

  assign done  = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign taken = branchTaken(funct3, alu_zero, alu_neg, alu_ovf, alu_carry);

  riscv_mc_alu_decoder #(
    .EXT_BRANCHES(EXT_BRANCHES)
  ) u_alu_decoder (
    .state_i        (state_q),
    .op_i           (op),
    .funct3_i       (funct3),
    .funct7b5_i     (funct7b5),
    .alu_control_o  (alu_control),
    .imm_src_o      (imm_src),
    .funct_illegal_o(functIllegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign illegal_d = illegal_q | (state_d == ST_HALT);

  always_comb begin
    state_d    = state_q;
    memReqS    = 1'b0;
    memWeS     = 1'b0;
    irWriteS   = 1'b0;
    pcWriteS   = 1'b0;
    regWriteS  = 1'b0;
    adr_src    = ADR_PC;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    result_src = RES_ALUOUT;
    case (state_q)
      ST_FETCH: begin
        memReqS    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        if (done) begin
          irWriteS = 1'b1;
          pcWriteS = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      // Decode also precomputes oldPC+imm into ALUOut for branch/jal targets.
      ST_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = ST_MEMADR;
          OP_RTYPE:          state_d = ST_EXECR;
          OP_ITYPE:          state_d = ST_EXECI;
          OP_BRANCH:         state_d = ST_BRANCH;
          OP_JAL:            state_d = ST_JAL;
          default:           state_d = ILLEGAL_NEXT;
        endcase
        if (functIllegal) state_d = ILLEGAL_NEXT;
      end
      ST_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_d   = (op == OP_LOAD) ? ST_MEMREAD : ST_MEMWRITE;
      end
      ST_MEMREAD: begin
        memReqS = 1'b1;
        adr_src = ADR_ALUOUT;
        if (done) state_d = ST_MEMWB;
      end
      ST_MEMWB: begin
        result_src = RES_RDATA;
        regWriteS  = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_MEMWRITE: begin
        memReqS = 1'b1;
        memWeS  = 1'b1;
        adr_src = ADR_ALUOUT;
        if (done) state_d = ST_FETCH;
      end
      ST_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        state_d   = ST_ALUWB;
      end
      ST_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        state_d   = ST_ALUWB;
      end
      ST_ALUWB: begin
        regWriteS = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        pcWriteS  = taken;
        state_d   = ST_FETCH;
      end
      // ALUWB then writes rd from the oldPC+4 latched here.
      ST_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pcWriteS  = 1'b1;
        state_d   = ST_ALUWB;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // Reset suppresses every side effect, including an access in mid-wait.
  assign mem_req   = memReqS & ~rst;
  assign mem_we    = memWeS & memReqS & ~rst;
  assign ir_write  = irWriteS & ~rst;
  assign pc_write  = pcWriteS & ~rst;
  assign reg_write = regWriteS & ~rst;
  assign illegal   = illegal_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_riscv_mc_control.sv
// Directed scoreboard bench for riscv_mc_control: per-cycle expectations are
// queued with each stimulus step and popped when the outputs are sampled.
module tb_riscv_mc_control;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
                         S_MEMREAD = 4'd3, S_MEMWB = 4'd4, S_MEMWRITE = 4'd5,
                         S_EXECR = 4'd6, S_EXECI = 4'd7, S_ALUWB = 4'd8,
                         S_BRANCH = 4'd9, S_JAL = 4'd10, S_HALT = 4'd11;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111,
                         BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, aluZero, aluNeg, aluOvf, aluCarry, memReady;
  logic       memReq, memWe, adrSrc, irWrite, pcWrite, regWrite, illegal;
  logic [1:0] aluSrcA, aluSrcB, resultSrc, immSrc;
  logic [2:0] aluControl;
  logic [3:0] stateDbg;

  logic       memReq2, memWe2, adrSrc2, irWrite2, pcWrite2, regWrite2, illegal2;
  logic [1:0] aluSrcA2, aluSrcB2, resultSrc2, immSrc2;
  logic [2:0] aluControl2;
  logic [3:0] stateDbg2;

  typedef struct {
    string      tag;
    logic [3:0] state;
    logic       memReq, memWe, adrSrc, irWrite, pcWrite, regWrite;
    logic [1:0] resultSrc;
    logic [2:0] aluCtl;
    logic       illegal;
  } exp_t;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  riscv_mc_control dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .alu_zero(aluZero), .alu_neg(aluNeg), .alu_ovf(aluOvf), .alu_carry(aluCarry),
    .mem_ready(memReady), .mem_req(memReq), .mem_we(memWe), .adr_src(adrSrc),
    .ir_write(irWrite), .pc_write(pcWrite), .reg_write(regWrite),
    .alu_src_a(aluSrcA), .alu_src_b(aluSrcB), .result_src(resultSrc),
    .imm_src(immSrc), .alu_control(aluControl), .illegal(illegal),
    .state_dbg(stateDbg)
  );

  // Second instance with only beq legal, fed the same instruction stream.
  riscv_mc_control #(.EXT_BRANCHES(0)) dut2 (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .alu_zero(aluZero), .alu_neg(aluNeg), .alu_ovf(aluOvf), .alu_carry(aluCarry),
    .mem_ready(memReady), .mem_req(memReq2), .mem_we(memWe2), .adr_src(adrSrc2),
    .ir_write(irWrite2), .pc_write(pcWrite2), .reg_write(regWrite2),
    .alu_src_a(aluSrcA2), .alu_src_b(aluSrcB2), .result_src(resultSrc2),
    .imm_src(immSrc2), .alu_control(aluControl2), .illegal(illegal2),
    .state_dbg(stateDbg2)
  );

  function automatic exp_t mk(input string tag, input logic [3:0] st,
                              input logic mr, input logic mw, input logic ad,
                              input logic ir, input logic pc, input logic rw,
                              input logic [1:0] rs, input logic [2:0] alu,
                              input logic il);
    exp_t e;
    e.tag = tag; e.state = st; e.memReq = mr; e.memWe = mw; e.adrSrc = ad;
    e.irWrite = ir; e.pcWrite = pc; e.regWrite = rw; e.resultSrc = rs;
    e.aluCtl = alu; e.illegal = il;
    return e;
  endfunction

  task automatic cmp(input string tag, input string field,
                     input logic [3:0] obs, input logic [3:0] expv);
    if (!$isunknown(expv)) begin
      checks++;
      assert (obs === expv) else begin
        failures++;
        $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, expv);
      end
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard empty observed=0 expected=1");
    end else begin
      e = expQ.pop_front();
      cmp(e.tag, "state", stateDbg, e.state);
      cmp(e.tag, "mem_req", {3'b0, memReq}, {3'b0, e.memReq});
      cmp(e.tag, "mem_we", {3'b0, memWe}, {3'b0, e.memWe});
      cmp(e.tag, "adr_src", {3'b0, adrSrc}, {3'b0, e.adrSrc});
      cmp(e.tag, "ir_write", {3'b0, irWrite}, {3'b0, e.irWrite});
      cmp(e.tag, "pc_write", {3'b0, pcWrite}, {3'b0, e.pcWrite});
      cmp(e.tag, "reg_write", {3'b0, regWrite}, {3'b0, e.regWrite});
      cmp(e.tag, "result_src", {2'b0, resultSrc}, {2'b0, e.resultSrc});
      cmp(e.tag, "alu_control", {1'b0, aluControl}, {1'b0, e.aluCtl});
      cmp(e.tag, "illegal", {3'b0, illegal}, {3'b0, e.illegal});
    end
  endtask

  task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3,
                               input logic f7, input logic rdy);
    op = o; funct3 = f3; funct7b5 = f7; memReady = rdy;
  endtask

  // Queue the expectation for this cycle, sample mid-cycle, then advance.
  task automatic step(input exp_t e);
    expQ.push_back(e);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    aluZero = 0; aluNeg = 0; aluOvf = 0; aluCarry = 1;
    applyStimulus(LW, 3'b010, 1'b0, 1'b1);
    step(mk("rst_a", S_FETCH, 0, 0, 0, 0, 0, 0, 2'b10, 3'b000, 0));
    step(mk("rst_b", S_FETCH, 0, 0, 0, 0, 0, 0, 2'b10, 3'b000, 0));
    rst = 1'b0;

    // lw, zero wait states
    step(mk("lw_fetch", S_FETCH, 1, 0, 0, 1, 1, 0, 2'b10, 3'b000, 0));
    step(mk("lw_decode", S_DECODE, 0, 0, 'x, 0, 0, 0, 'x, 3'b000, 0));
    step(mk("lw_memadr", S_MEMADR, 0, 0, 'x, 0, 0, 0, 'x, 3'b000, 0));
    step(mk("lw_memread", S_MEMREAD, 1, 0, 1, 0, 0, 0, 'x, 'x, 0));
    step(mk("lw_memwb", S_MEMWB, 0, 0, 'x, 0, 0, 1, 2'b01, 'x, 0));

    // sw with three wait cycles in MEMWRITE
    applyStimulus(SW, 3'b010, 1'b0, 1'b1);
    step(mk("sw_fetch", S_FETCH, 1, 0, 0, 1, 1, 0, 2'b10, 3'b000, 0));
    step(mk("sw_decode", S_DECODE, 0, 0, 'x, 0, 0, 0, 'x, 3'b000, 0));
    step(mk("sw_memadr", S_MEMADR, 0, 0, 'x, 0, 0, 0, 'x, 3'b000, 0));
    memReady = 1'b0;
    for (int i = 0; i < 3; i++)
      step(mk("sw_wait", S_MEMWRITE, 1, 1, 1, 0, 0, 0, 'x, 'x, 0));
    memReady = 1'b1;
    step(mk("sw_done", S_MEMWRITE, 1, 1, 1, 0, 0, 0, 'x, 'x, 0));

    // bne taken, with one fetch wait cycle
    applyStimulus(BR, 3'b001, 1'b0, 1'b0);
    aluZero = 0;
    step(mk("bne_fwait", S_FETCH, 1, 0, 0, 0, 0, 0, 2'b10, 3'b000, 0));
    memReady = 1'b1;
    step(mk("bne_fetch", S_FETCH, 1, 0, 0, 1, 1, 0, 2'b10, 3'b000, 0));
    step(mk("bne_decode", S_DECODE, 0, 0, 'x, 0, 0, 0, 'x, 3'b000, 0));
    step(mk("bne_taken", S_BRANCH, 0, 0, 'x, 0, 1, 0, 2'b00, 3'b001, 0));
    cmp("ext0_bne", "state", stateDbg2, S_HALT);
    cmp("ext0_bne", "illegal", {3'b0, illegal2}, 4'd1);

    // bne not taken
    aluZero = 1;
    step(mk("bne2_fetch", S_FETCH, 1, 0, 0, 1, 1, 0, 2'b10, 3'b000, 0));
    step(mk("bne2_decode", S_DECODE, 0, 0, 'x, 0, 0, 0, 'x, 3'b000, 0));
    step(mk("bne_nt", S_BRANCH, 0, 0, 'x, 0, 0, 0, 2'b00, 3'b001, 0));

    // blt with neg^ovf = 0: not taken
    applyStimulus(BR, 3'b100, 1'b0, 1'b1);
    aluZero = 0; aluNeg = 1; aluOvf = 1;
    step(mk("blt_fetch", S_FETCH, 1, 0, 0, 1, 1, 0, 2'b10, 3'b000, 0));
    step(mk("blt_decode", S_DECODE, 0, 0, 'x, 0, 0, 0, 'x, 3'b000, 0));
    step(mk("blt_nt", S_BRANCH, 0, 0, 'x, 0, 0, 0, 2'b00, 3'b001, 0));

    // bltu with borrow: taken
    applyStimulus(BR, 3'b110, 1'b0, 1'b1);
    aluNeg = 0; aluOvf = 0; aluCarry = 0;
    step(mk("bltu_fetch", S_FETCH, 1, 0, 0, 1, 1, 0, 2'b10, 3'b000, 0));
    step(mk("bltu_decode", S_DECODE, 0, 0, 'x, 0, 0, 0, 'x, 3'b000, 0));
    step(mk("bltu_taken", S_BRANCH, 0, 0, 'x, 0, 1, 0, 2'b00, 3'b001, 0));
    aluCarry = 1;

    // R-type sub
    applyStimulus(RT, 3'b000, 1'b1, 1'b1);
    step(mk("sub_fetch", S_FETCH, 1, 0, 0, 1, 1, 0, 2'b10, 3'b000, 0));
    step(mk("sub_decode", S_DECODE, 0, 0, 'x, 0, 0, 0, 'x, 3'b000, 0));
    step(mk("sub_exec", S_EXECR, 0, 0, 'x, 0, 0, 0, 'x, 3'b001, 0));
    step(mk("sub_wb", S_ALUWB, 0, 0, 'x, 0, 0, 1, 2'b00, 'x, 0));

    // addi with funct7b5 set still adds
    applyStimulus(IT, 3'b000, 1'b1, 1'b1);
    step(mk("addi_fetch", S_FETCH, 1, 0, 0, 1, 1, 0, 2'b10, 3'b000, 0));
    step(mk("addi_decode", S_DECODE, 0, 0, 'x, 0, 0, 0, 'x, 3'b000, 0));
    step(mk("addi_exec", S_EXECI, 0, 0, 'x, 0, 0, 0, 'x, 3'b000, 0));
    step(mk("addi_wb", S_ALUWB, 0, 0, 'x, 0, 0, 1, 2'b00, 'x, 0));

    // slt (R) and andi (I) decodes
    applyStimulus(RT, 3'b010, 1'b0, 1'b1);
    step(mk("slt_fetch", S_FETCH, 1, 0, 0, 1, 1, 0, 2'b10, 3'b000, 0));
    step(mk("slt_decode", S_DECODE, 0, 0, 'x, 0, 0, 0, 'x, 3'b000, 0));
    step(mk("slt_exec", S_EXECR, 0, 0, 'x, 0, 0, 0, 'x, 3'b101, 0));
    step(mk("slt_wb", S_ALUWB, 0, 0, 'x, 0, 0, 1, 2'b00, 'x, 0));
    applyStimulus(IT, 3'b111, 1'b0, 1'b1);
    step(mk("andi_fetch", S_FETCH, 1, 0, 0, 1, 1, 0, 2'b10, 3'b000, 0));
    step(mk("andi_decode", S_DECODE, 0, 0, 'x, 0, 0, 0, 'x, 3'b000, 0));
    step(mk("andi_exec", S_EXECI, 0, 0, 'x, 0, 0, 0, 'x, 3'b010, 0));
    step(mk("andi_wb", S_ALUWB, 0, 0, 'x, 0, 0, 1, 2'b00, 'x, 0));

    // jal
    applyStimulus(JL, 3'b000, 1'b0, 1'b1);
    step(mk("jal_fetch", S_FETCH, 1, 0, 0, 1, 1, 0, 2'b10, 3'b000, 0));
    step(mk("jal_decode", S_DECODE, 0, 0, 'x, 0, 0, 0, 'x, 3'b000, 0));
    step(mk("jal_jump", S_JAL, 0, 0, 'x, 0, 1, 0, 2'b00, 3'b000, 0));
    step(mk("jal_wb", S_ALUWB, 0, 0, 'x, 0, 0, 1, 2'b00, 'x, 0));

    // unknown opcode traps into sticky HALT
    applyStimulus(BAD, 3'b000, 1'b0, 1'b1);
    step(mk("bad_fetch", S_FETCH, 1, 0, 0, 1, 1, 0, 2'b10, 3'b000, 0));
    step(mk("bad_decode", S_DECODE, 0, 0, 'x, 0, 0, 0, 'x, 3'b000, 0));
    for (int i = 0; i < 20; i++)
      step(mk("halt", S_HALT, 0, 0, 'x, 0, 0, 0, 'x, 'x, 1));
    rst = 1'b1;
    step(mk("halt_rst", S_HALT, 0, 0, 'x, 0, 0, 0, 'x, 'x, 1));
    rst = 1'b0;
    cmp("ext0_rst", "state", stateDbg2, S_FETCH);
    cmp("ext0_rst", "illegal", {3'b0, illegal2}, 4'd0);

    // reset during a MEMREAD wait abandons the load
    applyStimulus(LW, 3'b010, 1'b0, 1'b1);
    step(mk("ab_fetch", S_FETCH, 1, 0, 0, 1, 1, 0, 2'b10, 3'b000, 0));
    step(mk("ab_decode", S_DECODE, 0, 0, 'x, 0, 0, 0, 'x, 3'b000, 0));
    step(mk("ab_memadr", S_MEMADR, 0, 0, 'x, 0, 0, 0, 'x, 3'b000, 0));
    memReady = 1'b0;
    step(mk("ab_wait", S_MEMREAD, 1, 0, 1, 0, 0, 0, 'x, 'x, 0));
    rst = 1'b1;
    step(mk("ab_rst", S_MEMREAD, 0, 0, 1, 0, 0, 0, 'x, 'x, 0));
    rst = 1'b0;
    step(mk("ab_after", S_FETCH, 1, 0, 0, 0, 0, 0, 2'b10, 3'b000, 0));

    // shift funct3 is illegal for R-type
    applyStimulus(RT, 3'b001, 1'b0, 1'b1);
    step(mk("sll_fetch", S_FETCH, 1, 0, 0, 1, 1, 0, 2'b10, 3'b000, 0));
    step(mk("sll_decode", S_DECODE, 0, 0, 'x, 0, 0, 0, 'x, 3'b000, 0));
    step(mk("sll_halt", S_HALT, 0, 0, 'x, 0, 0, 0, 'x, 'x, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_mc_control.md
Name: riscv_mc_control

Overview:
- Multi-cycle main controller for the next-generation RV32I core. It replaces the single-cycle combinational control path, so the core can use one shared instruction/data memory port.
- Sequences each instruction through a Moore FSM.
- Stalls on a valid/ready memory handshake.
- Decodes ALU operation and branch conditions.
- Traps unknown opcodes into a sticky HALT state.
- Sits between the instruction register and the datapath muxes, PC/IR enables, register file and memory port.

Parameters:
- MEM_HANDSHAKE, 1, 1: memory states wait for mem_ready. 0: mem_ready is ignored and memory completes in one cycle.
- EXT_BRANCHES, 1, 1: bne/blt/bge/bltu/bgeu are supported. 0: only beq is legal; other funct3 values are illegal.
- TRAP_ON_ILLEGAL, 1, 1: an unknown op/funct goes to HALT. 0: it is treated as a NOP and the FSM returns to FETCH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- op  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- alu_zero, alu_neg, alu_ovf, alu_carry  in  1 each  flags of the current ALU result; carry=1 means no borrow on subtract
- mem_ready  in  1  memory completes the access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write qualifier for mem_req
- adr_src  out  1  memory address select: 0=PC, 1=ALUOut
- ir_write  out  1  load the instruction register and oldPC
- pc_write  out  1  load PC from the result bus
- reg_write  out  1  register file write enable
- alu_src_a  out  2  ALU A select: 00=PC, 01=oldPC, 10=rs1
- alu_src_b  out  2  ALU B select: 00=rs2, 01=imm, 10=const 4
- result_src  out  2  result bus select: 00=ALUOut, 01=read data, 10=ALU result
- imm_src  out  2  immediate format: 00=I, 01=S, 10=B, 11=J
- alu_control  out  3  ALU operation code
- illegal  out  1  sticky flag, set on entry to HALT
- state_dbg  out  4  current state encoding, for debug

Behaviour:
- Reset:
  - rst sampled high: next state is FETCH and illegal is cleared.
  - While rst is high, mem_req, mem_we, ir_write, pc_write and reg_write are forced to 0.
  - Reset asserted mid-wait abandons the access with no write side effects.
- All outputs are Moore outputs of the state, with three exceptions:
  - ir_write and pc_write in FETCH are qualified by the memory-done condition.
  - pc_write in BRANCH is qualified by the taken condition.
  - alu_control and imm_src are combinational decodes of op/funct3/funct7b5.
- "done" means mem_ready when MEM_HANDSHAKE=1, and constant 1 otherwise.
- State transitions:
  - FETCH: mem_req=1, adr_src=0, A=00, B=10, add, result_src=10. On done: ir_write=1, pc_write=1, go to DECODE. Otherwise stay.
  - DECODE: A=01, B=01, add (precomputes the branch/jal target into ALUOut). Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - anything else -> HALT (TRAP_ON_ILLEGAL=1) or FETCH (TRAP_ON_ILLEGAL=0)
  - MEMADR: A=10, B=01, add. Go to MEMREAD if op is load, else MEMWRITE.
  - MEMREAD: mem_req=1, adr_src=1. On done go to MEMWB, else stay.
  - MEMWB: result_src=01, reg_write=1, go to FETCH.
  - MEMWRITE: mem_req=1, mem_we=1, adr_src=1. On done go to FETCH, else stay. mem_we is never high without mem_req.
  - EXECR: A=10, B=00. EXECI: A=10, B=01. Both go to ALUWB.
  - ALUWB: result_src=00, reg_write=1, go to FETCH.
  - BRANCH: A=10, B=00, sub, result_src=00. pc_write=taken. Go to FETCH.
  - JAL: A=01, B=10, add, result_src=00, pc_write=1. Go to ALUWB, which writes rd=oldPC+4.
  - HALT: all enables 0, illegal=1. Only rst leaves HALT.
- Branch taken conditions by funct3:
  - 000: zero
  - 001: !zero
  - 100: neg^ovf
  - 101: !(neg^ovf)
  - 110: !carry
  - 111: carry
  - 010/011 are illegal.
- alu_control decode:
  - The control path forces add in FETCH/DECODE/MEMADR/JAL and sub in BRANCH.
  - In EXECR/EXECI, decode funct3:
    - 000: sub if (EXECR and funct7b5) else add
    - 010: slt
    - 011: sltu
    - 100: xor
    - 110: or
    - 111: and
    - 001/101 (shifts): illegal
- imm_src by op: I for loads/ALU-immediate, S for stores, B for branches, J for jal.
- Cycle counts with zero wait states:
  - load: 5
  - store: 4
  - R/I-type: 4
  - branch: 3
  - jal: 4
- Each memory wait cycle adds one cycle.

Decomposition:
- Package riscv_mc_pkg contains:
  - state enum (4-bit): FETCH=0, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, HALT
  - opcode constants
  - ALU codes: ADD=000, SUB=001, AND=010, OR=011, XOR=100, SLT=101, SLTU=110
  - mux-select constants
- One sub-module, riscv_mc_alu_decoder: the combinational alu_control/imm_src/illegal-funct decode.

Test Plan:
- Reset, then lw with mem_ready high in both the fetch and read cycles -> states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; reg_write=1 exactly in cycle 5; result_src=01.
- sw with mem_ready held low 3 cycles in MEMWRITE -> mem_req=1, mem_we=1, adr_src=1 held 4 cycles; FETCH entered on the cycle after mem_ready=1; reg_write never 1.
- bne (funct3=001) with alu_zero=0 -> pc_write=1 in BRANCH. Same with alu_zero=1 -> pc_write=0. With EXT_BRANCHES=0, bne -> HALT, illegal=1.
- blt with neg=1, ovf=1 -> not taken. bltu with carry=0 -> taken, alu_control=001.
- R-type sub (funct3=000, funct7b5=1) -> alu_control=001 in EXECR; ALUWB asserts reg_write with result_src=00. The same funct with op=0010011 -> 000 (addi).
- op=1111111 -> HALT, illegal=1 persists for 20 cycles; rst high for one cycle -> FETCH, illegal=0. rst asserted during a MEMREAD wait -> no reg_write, state FETCH.
